// File: rtl/pc_sequencer.sv
// Program-counter stage of the fetch path.
// Holds the PC and feeds it to an external adder, whose result is the next sequential PC.
// Presents the PC to instruction memory over a valid/ready handshake.
// Handles stalls, branch/jump redirects, halt, and trapping of misaligned redirect targets.
module pc_sequencer #(
   parameter int unsigned   N        = 32,
   parameter logic [N-1:0]  RESET_PC = '0,
   parameter int unsigned   STEP     = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   output logic [N-1:0] add_a,
   output logic [N-1:0] add_b,
   input  logic [N-1:0] add_y,
   input  logic         stall,
   input  logic         redirect_valid,
   input  logic [N-1:0] redirect_pc,
   input  logic         halt_req,
   output logic         fetch_valid,
   input  logic         fetch_ready,
   output logic [N-1:0] pc,
   output logic         halted,
   output logic         misalign_err,
   output logic [N-1:0] fetch_count
);

   localparam logic [N-1:0] STEP_W     = N'(STEP);
   // Low address bits that must be zero for a STEP-aligned target; empty when STEP==1.
   localparam logic [N-1:0] ALIGN_MASK = N'(STEP - 1);

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t       state;
   state_t       state_next;
   logic [N-1:0] pc_next;
   logic [N-1:0] count_next;
   logic         misalign_next;
   logic         halt_pending;
   logic         halt_pending_next;
   logic         accept;
   logic         misaligned;

   // Adder operands and handshake decode.
   assign add_a       = pc;
   assign add_b       = STEP_W;
   assign fetch_valid = (state == ST_RUN) && !stall;
   assign accept      = fetch_valid && fetch_ready;
   assign misaligned  = (redirect_pc & ALIGN_MASK) != '0;
   assign halted      = (state == ST_HALTED);

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_BOOT;
         pc           <= RESET_PC;
         misalign_err <= 1'b0;
         halt_pending <= 1'b0;
         fetch_count  <= '0;
      end else begin
         state        <= state_next;
         pc           <= pc_next;
         misalign_err <= misalign_next;
         halt_pending <= halt_pending_next;
         fetch_count  <= count_next;
      end
   end

   // Next-state and next-PC selection, highest-priority event first.
   always_comb begin
      state_next        = state;
      pc_next           = pc;
      misalign_next     = misalign_err;
      halt_pending_next = halt_pending;
      count_next        = fetch_count;
      case (state)
         ST_BOOT: begin
            state_next = ST_RUN;
            if (halt_req) halt_pending_next = 1'b1;
         end
         ST_RUN: begin
            if (halt_req) halt_pending_next = 1'b1;
            if (accept)   count_next = fetch_count + N'(1);
            if (redirect_valid && misaligned) begin
               misalign_next = 1'b1;
               state_next    = ST_HALTED;
            end else if (redirect_valid) begin
               pc_next = redirect_pc;
            end else if (halt_pending && !(fetch_valid && !fetch_ready)) begin
               // Only halt once no presented fetch is left waiting for ready.
               state_next = ST_HALTED;
            end else if (accept) begin
               pc_next = add_y;
            end
         end
         ST_HALTED: begin
            state_next = ST_HALTED;
         end
         default: begin
            state_next = ST_BOOT;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 32-bit instance for the main behaviour and
// an 8-bit instance for the fetch_count / pc wrap-around cases.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] add_a, add_b, add_y;
   logic        stall, redirect_valid, halt_req, fetch_ready;
   logic [31:0] redirect_pc;
   logic        fetch_valid, halted, misalign_err;
   logic [31:0] pc, fetch_count;

   logic        s_rst_n, s_ready;
   logic [7:0]  s_add_a, s_add_b, s_add_y, s_pc, s_count;
   logic        s_valid, s_halted, s_mis;

   int unsigned total  = 0;
   int unsigned passed = 0;

   always #5 clk = ~clk;

   // Behavioural adders closing the loop around each instance.
   assign add_y   = add_a + add_b;
   assign s_add_y = s_add_a + s_add_b;

   pc_sequencer #(.N(32), .RESET_PC(32'h0), .STEP(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .add_a(add_a), .add_b(add_b), .add_y(add_y),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt_req(halt_req), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
      .pc(pc), .halted(halted), .misalign_err(misalign_err), .fetch_count(fetch_count)
   );

   pc_sequencer #(.N(8), .RESET_PC(8'h0), .STEP(4)) u_small (
      .clk(clk), .rst_n(s_rst_n), .add_a(s_add_a), .add_b(s_add_b), .add_y(s_add_y),
      .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(8'h00),
      .halt_req(1'b0), .fetch_valid(s_valid), .fetch_ready(s_ready),
      .pc(s_pc), .halted(s_halted), .misalign_err(s_mis), .fetch_count(s_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Advance one clock, leave time just past the edge for sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      halt_req = 1'b0; fetch_ready = 1'b1;
      s_rst_n = 1'b0; s_ready = 1'b1;

      // Reset and boot
      step(); step();
      check("rst_pc", pc, 32'h0);
      check("rst_halted", {31'b0, halted}, 32'h0);
      check("rst_mis", {31'b0, misalign_err}, 32'h0);
      check("rst_count", fetch_count, 32'h0);
      check("rst_valid", {31'b0, fetch_valid}, 32'h0);
      rst_n = 1'b1; #1;
      check("boot_valid", {31'b0, fetch_valid}, 32'h0);
      step();
      check("run_valid", {31'b0, fetch_valid}, 32'h1);
      check("run_pc0", pc, 32'h0);
      check("add_a", add_a, 32'h0);
      check("add_b", add_b, 32'h4);
      step();
      check("pc4", pc, 32'h4);
      check("cnt1", fetch_count, 32'h1);
      step();
      check("pc8", pc, 32'h8);
      check("cnt2", fetch_count, 32'h2);

      // Backpressure at pc=8
      fetch_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_valid", {31'b0, fetch_valid}, 32'h1);
         step();
         check("bp_pc", pc, 32'h8);
         check("bp_cnt", fetch_count, 32'h2);
      end
      fetch_ready = 1'b1;
      step();
      check("pc12", pc, 32'h0000000C);
      check("cnt3", fetch_count, 32'h3);

      // Stall drops valid and holds pc
      stall = 1'b1; #1;
      check("stall_valid", {31'b0, fetch_valid}, 32'h0);
      step();
      check("stall_pc", pc, 32'h0000000C);
      check("stall_cnt", fetch_count, 32'h3);

      // Redirect under stall and backpressure
      fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
      step();
      check("redir_pc", pc, 32'h100);
      check("redir_cnt", fetch_count, 32'h3);
      redirect_valid = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
      step();
      check("pc104", pc, 32'h104);
      step();
      check("pc108", pc, 32'h108);
      check("cnt5", fetch_count, 32'h5);

      // Misaligned redirect traps
      fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h102;
      step();
      check("mis_pc", pc, 32'h108);
      check("mis_err", {31'b0, misalign_err}, 32'h1);
      check("mis_halted", {31'b0, halted}, 32'h1);
      check("mis_valid", {31'b0, fetch_valid}, 32'h0);
      fetch_ready = 1'b1; redirect_pc = 32'h200;
      step();
      check("hlt_ignore_pc", pc, 32'h108);
      check("hlt_ignore_cnt", fetch_count, 32'h5);
      check("hlt_valid", {31'b0, fetch_valid}, 32'h0);
      redirect_valid = 1'b0; rst_n = 1'b0;
      step();
      check("clr_mis", {31'b0, misalign_err}, 32'h0);
      check("clr_halted", {31'b0, halted}, 32'h0);
      check("clr_pc", pc, 32'h0);
      check("clr_cnt", fetch_count, 32'h0);

      // Wrap of pc at top of address space
      rst_n = 1'b1;
      step();
      fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
      step();
      check("top_pc", pc, 32'hFFFFFFFC);
      redirect_valid = 1'b0; fetch_ready = 1'b1; #1;
      check("top_add_a", add_a, 32'hFFFFFFFC);
      step();
      check("wrap_pc", pc, 32'h0);
      check("wrap_cnt", fetch_count, 32'h1);

      // Halt request while a fetch is waiting for ready
      fetch_ready = 1'b0; halt_req = 1'b1; #1;
      check("hreq_valid", {31'b0, fetch_valid}, 32'h1);
      step();
      halt_req = 1'b0;
      check("hreq_pc", pc, 32'h0);
      check("hreq_run", {31'b0, halted}, 32'h0);
      step();
      check("hreq_wait", {31'b0, halted}, 32'h0);
      fetch_ready = 1'b1;
      step();
      check("halt_cnt", fetch_count, 32'h2);
      check("halt_state", {31'b0, halted}, 32'h1);
      check("halt_pc", pc, 32'h0);
      check("halt_valid", {31'b0, fetch_valid}, 32'h0);
      step();
      check("halt_hold_cnt", fetch_count, 32'h2);

      // Reset mid-run
      rst_n = 1'b0; step(); rst_n = 1'b1;
      step(); step(); step();
      check("mid_pc", pc, 32'h8);
      check("mid_cnt", fetch_count, 32'h2);
      rst_n = 1'b0;
      step();
      check("mid_rst_pc", pc, 32'h0);
      check("mid_rst_cnt", fetch_count, 32'h0);
      check("mid_rst_valid", {31'b0, fetch_valid}, 32'h0);
      rst_n = 1'b1;

      // Narrow instance: fetch_count and pc both wrap
      s_rst_n = 1'b1;
      step();
      check("s_pc0", {24'b0, s_pc}, 32'h0);
      for (int i = 0; i < 255; i++) step();
      check("s_cnt_ff", {24'b0, s_count}, 32'hFF);
      check("s_pc_fc", {24'b0, s_pc}, 32'hFC);
      step();
      check("s_cnt_wrap", {24'b0, s_count}, 32'h0);
      check("s_pc_wrap", {24'b0, s_pc}, 32'h0);
      check("s_flags", {30'b0, s_halted, s_mis}, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
